// File: rtl/ogege_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ogege_pkg
//  Description : Shared definitions for the ogege scroll command path:
//                scroll opcode, configuration field encodings, command bit
//                positions, sequencer state enum and a command packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ogege_pkg;

    // Opcode understood by text_area8x8 as "set scroll offset"
    localparam logic [3:0] SCROLL_OP    = 4'b0011;

    // Configuration register select (i_cfg_field)
    localparam logic [2:0] CFG_ENABLE   = 3'd0;
    localparam logic [2:0] CFG_VEL_X    = 3'd1;
    localparam logic [2:0] CFG_VEL_Y    = 3'd2;
    localparam logic [2:0] CFG_WRAP_X   = 3'd3;
    localparam logic [2:0] CFG_WRAP_Y   = 3'd4;
    localparam logic [2:0] CFG_OFFSET_X = 3'd5;
    localparam logic [2:0] CFG_OFFSET_Y = 3'd6;
    localparam logic [2:0] CFG_PERIOD   = 3'd7;

    // Command word layout: {op[31:28], layer[27:25], y[24:16], 6'b0, x[9:0]}
    localparam int CMD_OP_LSB    = 28;
    localparam int CMD_LAYER_LSB = 25;
    localparam int CMD_Y_LSB     = 16;
    localparam int CMD_X_LSB     = 0;

    // Scroll offset widths carried in the command
    localparam int OFF_X_W = 10;
    localparam int OFF_Y_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        EMIT   = 2'd2
    } seq_state_t;

    function automatic logic [31:0] scroll_cmd(
        input logic [2:0]         layer,
        input logic [OFF_Y_W-1:0] y,
        input logic [OFF_X_W-1:0] x
    );
        logic [31:0] cmd;
        cmd = '0;
        cmd[CMD_OP_LSB    +: 4]       = SCROLL_OP;
        cmd[CMD_LAYER_LSB +: 3]       = layer;
        cmd[CMD_Y_LSB     +: OFF_Y_W] = y;
        cmd[CMD_X_LSB     +: OFF_X_W] = x;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_axis_step.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_axis_step
//  Description : Combinational wrap adder for one scroll axis.
//                o_next = i_offset + i_vel, folded back into [0, i_wrap].
//  Ports       : i_offset [W-1:0]  current offset
//                i_vel    [VW-1:0] signed velocity (two's complement)
//                i_wrap   [W-1:0]  largest legal offset
//                o_next   [W-1:0]  stepped and wrapped offset
//  Revision    : 1.0 - initial release
// ============================================================================
module scroll_axis_step #(
    parameter int W  = 10,
    parameter int VW = 4
) (
    input  logic [W-1:0]  i_offset,
    input  logic [VW-1:0] i_vel,
    input  logic [W-1:0]  i_wrap,
    output logic [W-1:0]  o_next
);

    // One extra bit holds the sign of the raw sum; |vel| <= wrap keeps a
    // single correction sufficient.
    logic [W:0] w_sum;
    logic [W:0] w_span;
    logic [W:0] w_fixed;
    logic       w_neg;
    logic       w_over;
    logic       w_unused_msb;

    assign w_span = {1'b0, i_wrap} + {{W{1'b0}}, 1'b1};
    assign w_sum  = {1'b0, i_offset} + {{(W + 1 - VW){i_vel[VW-1]}}, i_vel};
    assign w_neg  = w_sum[W];
    assign w_over = !w_neg && (w_sum > {1'b0, i_wrap});

    always_comb begin
        w_fixed = w_sum;
        if (w_neg) begin
            w_fixed = w_sum + w_span;
        end else if (w_over) begin
            w_fixed = w_sum - w_span;
        end
    end

    assign o_next       = w_fixed[W-1:0];
    assign w_unused_msb = w_fixed[W];

endmodule
`default_nettype wire

// File: rtl/scroll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_sequencer
//  Description : Per-frame scroll command generator. Holds per-layer scroll
//                offsets, velocities, wrap limits and enables; at every frame
//                end it steps the enabled layers and then emits one scroll
//                command per enabled layer over a valid/ready port.
//  Ports       : i_pix_clk, i_rst        clock, synchronous active-high reset
//                i_scan_column/i_scan_row current raster position
//                i_cfg_we/layer/field/data configuration write port
//                o_cmd_valid/i_cmd_ready/o_cmd_data  command handshake
//                o_busy         sequencer not idle
//                o_overrun      sticky: frame end seen while busy
//                o_frame_count  frames since the last period rollover
//  Revision    : 1.0 - initial release
// ============================================================================
module scroll_sequencer
    import ogege_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int HSZ        = 10,
    parameter int VSZ        = 9,
    parameter int HRES       = 640,
    parameter int VRES       = 480,
    parameter int VW         = 4,
    parameter int PW         = 6,
    parameter int WRAP_X_DEF = 671,
    parameter int WRAP_Y_DEF = 511,
    parameter int PERIOD_DEF = 60
) (
    input  logic           i_pix_clk,
    input  logic           i_rst,
    input  logic [HSZ-1:0] i_scan_column,
    input  logic [VSZ-1:0] i_scan_row,
    input  logic           i_cfg_we,
    input  logic [2:0]     i_cfg_layer,
    input  logic [2:0]     i_cfg_field,
    input  logic [15:0]    i_cfg_data,
    output logic           o_cmd_valid,
    input  logic           i_cmd_ready,
    output logic [31:0]    o_cmd_data,
    output logic           o_busy,
    output logic           o_overrun,
    output logic [PW-1:0]  o_frame_count
);

    localparam logic [2:0] c_last_idx = 3'(NUM_LAYERS - 1);

    // ---------------------------------------------------------------- state
    seq_state_t              r_state;
    logic [2:0]              r_idx;
    logic                    r_roll;
    logic [NUM_LAYERS-1:0]   r_en;
    logic [OFF_X_W-1:0]      r_off_x  [NUM_LAYERS];
    logic [OFF_Y_W-1:0]      r_off_y  [NUM_LAYERS];
    logic [VW-1:0]           r_vel_x  [NUM_LAYERS];
    logic [VW-1:0]           r_vel_y  [NUM_LAYERS];
    logic [OFF_X_W-1:0]      r_wrap_x [NUM_LAYERS];
    logic [OFF_Y_W-1:0]      r_wrap_y [NUM_LAYERS];
    logic [PW-1:0]           r_period;
    logic [PW-1:0]           r_frame_count;
    logic                    r_overrun;
    logic                    r_cmd_valid;
    logic [31:0]             r_cmd_data;
    logic                    r_busy;

    // ---------------------------------------------------------- combinational
    logic                    w_tick;
    logic                    w_rollover;
    logic                    w_cfg_layer_ok;
    logic                    w_unused;
    logic [OFF_X_W-1:0]      w_sel_off_x, w_sel_wrap_x, w_step_x;
    logic [OFF_Y_W-1:0]      w_sel_off_y, w_sel_wrap_y, w_step_y;
    logic [VW-1:0]           w_sel_vel_x, w_sel_vel_y;
    logic [OFF_X_W-1:0]      w_off_x_nxt [NUM_LAYERS];
    logic [OFF_Y_W-1:0]      w_off_y_nxt [NUM_LAYERS];
    logic                    w_first_found, w_next_found;
    logic [2:0]              w_first_idx, w_next_idx, w_tgt_idx;
    logic [OFF_X_W-1:0]      w_tgt_x;
    logic [OFF_Y_W-1:0]      w_tgt_y;
    logic [31:0]             w_tgt_cmd;

    assign w_tick = (i_scan_column == HSZ'(HRES - 1)) && (i_scan_row == VSZ'(VRES - 1));
    assign w_rollover = (r_period != '0) && (r_frame_count == (r_period - PW'(1)));
    assign w_cfg_layer_ok = ({1'b0, i_cfg_layer} < 4'(NUM_LAYERS));
    assign w_unused = &{1'b0, i_cfg_data};

    // Layer-indexed mux feeding the single pair of axis adders
    always_comb begin
        w_sel_off_x  = '0;
        w_sel_off_y  = '0;
        w_sel_vel_x  = '0;
        w_sel_vel_y  = '0;
        w_sel_wrap_x = '0;
        w_sel_wrap_y = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (r_idx == 3'(k)) begin
                w_sel_off_x  = r_off_x[k];
                w_sel_off_y  = r_off_y[k];
                w_sel_vel_x  = r_vel_x[k];
                w_sel_vel_y  = r_vel_y[k];
                w_sel_wrap_x = r_wrap_x[k];
                w_sel_wrap_y = r_wrap_y[k];
            end
        end
    end

    scroll_axis_step #(.W(OFF_X_W), .VW(VW)) u_step_x (
        .i_offset (w_sel_off_x),
        .i_vel    (w_sel_vel_x),
        .i_wrap   (w_sel_wrap_x),
        .o_next   (w_step_x)
    );

    scroll_axis_step #(.W(OFF_Y_W), .VW(VW)) u_step_y (
        .i_offset (w_sel_off_y),
        .i_vel    (w_sel_vel_y),
        .i_wrap   (w_sel_wrap_y),
        .o_next   (w_step_y)
    );

    // Next offset per layer: a software write beats the frame step
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        logic w_wr_x, w_wr_y, w_step_here;
        assign w_wr_x = i_cfg_we && w_cfg_layer_ok && (i_cfg_layer == 3'(k))
                        && (i_cfg_field == CFG_OFFSET_X);
        assign w_wr_y = i_cfg_we && w_cfg_layer_ok && (i_cfg_layer == 3'(k))
                        && (i_cfg_field == CFG_OFFSET_Y);
        assign w_step_here = (r_state == UPDATE) && (r_idx == 3'(k)) && r_en[k];
        assign w_off_x_nxt[k] = w_wr_x ? i_cfg_data[OFF_X_W-1:0] :
                                w_step_here ? (r_roll ? '0 : w_step_x) : r_off_x[k];
        assign w_off_y_nxt[k] = w_wr_y ? i_cfg_data[OFF_Y_W-1:0] :
                                w_step_here ? (r_roll ? '0 : w_step_y) : r_off_y[k];
    end

    // Lowest enabled layer overall, and lowest enabled layer above r_idx
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_next_found  = 1'b0;
        w_next_idx    = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (r_en[k]) begin
                w_first_found = 1'b1;
                w_first_idx   = 3'(k);
            end
            if (r_en[k] && (3'(k) > r_idx)) begin
                w_next_found = 1'b1;
                w_next_idx   = 3'(k);
            end
        end
    end

    // Command for the layer about to be presented. Built from the next-cycle
    // offsets so the last UPDATE step is already visible in the first command.
    assign w_tgt_idx = (r_state == EMIT) ? w_next_idx : w_first_idx;

    always_comb begin
        w_tgt_x = '0;
        w_tgt_y = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (w_tgt_idx == 3'(k)) begin
                w_tgt_x = w_off_x_nxt[k];
                w_tgt_y = w_off_y_nxt[k];
            end
        end
    end

    assign w_tgt_cmd = scroll_cmd(w_tgt_idx, w_tgt_y, w_tgt_x);

    // --------------------------------------------------------- sequencer FSM
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_roll        <= 1'b0;
            r_en          <= '0;
            r_period      <= PW'(PERIOD_DEF);
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_data    <= '0;
            r_busy        <= 1'b0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                r_off_x[k]  <= '0;
                r_off_y[k]  <= '0;
                r_vel_x[k]  <= '0;
                r_vel_y[k]  <= '0;
                r_wrap_x[k] <= OFF_X_W'(WRAP_X_DEF);
                r_wrap_y[k] <= OFF_Y_W'(WRAP_Y_DEF);
            end
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                r_off_x[k] <= w_off_x_nxt[k];
                r_off_y[k] <= w_off_y_nxt[k];
            end

            if (i_cfg_we) begin
                if (i_cfg_field == CFG_PERIOD) begin
                    r_period <= i_cfg_data[PW-1:0];
                end else if (w_cfg_layer_ok) begin
                    for (int k = 0; k < NUM_LAYERS; k++) begin
                        if (i_cfg_layer == 3'(k)) begin
                            case (i_cfg_field)
                                CFG_ENABLE: r_en[k]     <= i_cfg_data[0];
                                CFG_VEL_X:  r_vel_x[k]  <= i_cfg_data[VW-1:0];
                                CFG_VEL_Y:  r_vel_y[k]  <= i_cfg_data[VW-1:0];
                                CFG_WRAP_X: r_wrap_x[k] <= i_cfg_data[OFF_X_W-1:0];
                                CFG_WRAP_Y: r_wrap_y[k] <= i_cfg_data[OFF_Y_W-1:0];
                                default: ;
                            endcase
                        end
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state <= UPDATE;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_roll  <= w_rollover;
                        r_frame_count <= w_rollover ? '0 : (r_frame_count + PW'(1));
                    end
                end
                UPDATE: begin
                    if (w_tick) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_idx == c_last_idx) begin
                        if (w_first_found) begin
                            r_state     <= EMIT;
                            r_idx       <= w_first_idx;
                            r_cmd_valid <= 1'b1;
                            r_cmd_data  <= w_tgt_cmd;
                        end else begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                EMIT: begin
                    if (w_tick) begin
                        r_overrun <= 1'b1;
                    end
                    // o_cmd_valid is always high in EMIT
                    if (i_cmd_ready) begin
                        if (w_next_found) begin
                            r_idx      <= w_next_idx;
                            r_cmd_data <= w_tgt_cmd;
                        end else begin
                            r_state     <= IDLE;
                            r_idx       <= '0;
                            r_cmd_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_data    = r_cmd_data;
    assign o_busy        = r_busy;
    assign o_overrun     = r_overrun;
    assign o_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_scroll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scroll_sequencer
//  Description : Self-checking bench for scroll_sequencer with a frame-level
//                reference model (per-layer offsets stepped with integer
//                arithmetic, expected command queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_sequencer;

    localparam int NL   = 4;
    localparam int HSZ  = 10;
    localparam int VSZ  = 9;
    localparam int HRES = 640;
    localparam int VRES = 480;
    localparam int PW   = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [HSZ-1:0] col;
    logic [VSZ-1:0] row;
    logic           cfg_we;
    logic [2:0]     cfg_layer;
    logic [2:0]     cfg_field;
    logic [15:0]    cfg_data;
    logic           valid;
    logic           ready;
    logic [31:0]    data;
    logic           busy;
    logic           overrun;
    logic [PW-1:0]  fc;

    always #5 clk = ~clk;

    scroll_sequencer #(.NUM_LAYERS(NL)) dut (
        .i_pix_clk     (clk),
        .i_rst         (rst),
        .i_scan_column (col),
        .i_scan_row    (row),
        .i_cfg_we      (cfg_we),
        .i_cfg_layer   (cfg_layer),
        .i_cfg_field   (cfg_field),
        .i_cfg_data    (cfg_data),
        .o_cmd_valid   (valid),
        .i_cmd_ready   (ready),
        .o_cmd_data    (data),
        .o_busy        (busy),
        .o_overrun     (overrun),
        .o_frame_count (fc)
    );

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------ reference model
    int  mox [NL];
    int  moy [NL];
    int  mvx [NL];
    int  mvy [NL];
    int  mwx [NL];
    int  mwy [NL];
    bit  men [NL];
    int  mper;
    int  mfc;
    logic [31:0] exp_q [$];

    function automatic int wrap_step(input int o, input int v, input int w);
        int n;
        n = o + v;
        if (n > w) n = n - (w + 1);
        else if (n < 0) n = n + (w + 1);
        return n;
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) begin
            mox[l] = 0; moy[l] = 0; mvx[l] = 0; mvy[l] = 0;
            mwx[l] = 671; mwy[l] = 511; men[l] = 1'b0;
        end
        mper = 60;
        mfc  = 0;
        exp_q.delete();
    endfunction

    // One frame: frame counter, offsets, then the command list in layer order
    function automatic void model_tick();
        bit roll;
        roll = (mper != 0) && (mfc == mper - 1);
        mfc  = roll ? 0 : (mfc + 1) % 64;
        for (int l = 0; l < NL; l++) begin
            if (men[l]) begin
                if (roll) begin
                    mox[l] = 0; moy[l] = 0;
                end else begin
                    mox[l] = wrap_step(mox[l], mvx[l], mwx[l]);
                    moy[l] = wrap_step(moy[l], mvy[l], mwy[l]);
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (men[l]) exp_q.push_back({4'b0011, 3'(l), 9'(moy[l]), 6'b0, 10'(mox[l])});
        end
    endfunction

    function automatic int sext4(input int d);
        int v;
        v = d & 15;
        if (v > 7) v = v - 16;
        return v;
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; ready = 1'b1; col = '0; row = '0;
        cfg_layer = '0; cfg_field = '0; cfg_data = '0;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg(input int layer, input int field, input int d);
        cfg_we = 1'b1; cfg_layer = 3'(layer); cfg_field = 3'(field); cfg_data = 16'(d);
        step();
        cfg_we = 1'b0;
        if (field == 7) mper = d & 63;
        else if (layer < NL) begin
            case (field)
                0: men[layer] = d[0];
                1: mvx[layer] = sext4(d);
                2: mvy[layer] = sext4(d);
                3: mwx[layer] = d & 1023;
                4: mwy[layer] = d & 511;
                5: mox[layer] = d & 1023;
                6: moy[layer] = d & 511;
                default: ;
            endcase
        end
    endtask

    // Frame-end pulse; afterwards the raster sits on a non-tick position
    // (often same column, different row) to exercise the partial match.
    task automatic tick();
        col = HSZ'(HRES - 1); row = VSZ'(VRES - 1);
        step();
        row = VSZ'($urandom_range(0, VRES - 2));
        col = ($urandom_range(0, 1) == 0) ? HSZ'(HRES - 1) : HSZ'($urandom_range(0, HRES - 2));
    endtask

    // Full frame against the model with random back-pressure
    task automatic run_frame(input int rdy_pct, output logic [31:0] last);
        int          cyc;
        int          n_exp;
        bit          rd;
        bit          hold;
        logic [31:0] held;
        logic [31:0] e;
        last = '0;
        model_tick();
        n_exp = exp_q.size();
        ready = 1'b1;
        tick();
        for (int c = 0; c < NL; c++) begin
            total++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                bad++;
                $display("FAIL update_phase c=%0d: busy=%b valid=%b, required busy=1 valid=0", c, busy, valid);
            end
            step();
        end
        total++;
        if (valid !== (n_exp != 0) || busy !== (n_exp != 0)) begin
            bad++;
            $display("FAIL first_valid: valid=%b busy=%b, required %0b", valid, busy, n_exp != 0);
        end
        hold = 1'b0;
        held = '0;
        cyc  = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (hold) begin
                total++;
                if (valid !== 1'b1 || data !== held) begin
                    bad++;
                    $display("FAIL hold_stable: valid=%b data=%h, required 1 %h", valid, data, held);
                end
            end
            rd = ($urandom_range(1, 100) <= rdy_pct);
            ready = rd;
            hold = 1'b0;
            if (valid === 1'b1) begin
                if (rd) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_cmd: got %h, required none", data);
                    end else begin
                        e = exp_q.pop_front();
                        if (data !== e) begin
                            bad++;
                            $display("FAIL cmd: got %h, required %h", data, e);
                        end
                    end
                    last = data;
                end else begin
                    hold = 1'b1;
                    held = data;
                end
            end
            step();
            cyc++;
        end
        ready = 1'b1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: busy=%b valid=%b, required 0 0", busy, valid);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_cmds: %0d left, required 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (fc !== PW'(mfc)) begin
            bad++;
            $display("FAIL frame_count: got %0d, required %0d", fc, mfc);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || fc !== '0 || data !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b busy=%b ovr=%b fc=%0d data=%h, required all 0",
                     valid, busy, overrun, fc, data);
        end
    endtask

    task automatic test_single();
        logic [31:0] last;
        do_reset();
        cfg(0, 0, 1); cfg(0, 1, 1); cfg(0, 2, 1);
        run_frame(100, last);
        total++;
        if (last !== 32'h30010001) begin
            bad++;
            $display("FAIL single_cmd: got %h, required 30010001", last);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] last;
        do_reset();
        cfg(0, 0, 1); cfg(0, 5, 671); cfg(0, 1, 1);
        run_frame(100, last);
        total++;
        if (last[9:0] !== 10'd0) begin
            bad++;
            $display("FAIL wrap_up: x=%0d, required 0", last[9:0]);
        end
        cfg(0, 5, 0); cfg(0, 1, 14);
        run_frame(100, last);
        total++;
        if (last[9:0] !== 10'd670) begin
            bad++;
            $display("FAIL wrap_down: x=%0d, required 670", last[9:0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cfg(0, 0, 1); cfg(2, 0, 1); cfg(2, 5, 5); cfg(2, 6, 7);
        ready = 1'b0;
        tick();
        for (int c = 0; c < NL; c++) step();
        for (int c = 0; c < 3; c++) begin
            total++;
            if (valid !== 1'b1 || data !== 32'h30000000) begin
                bad++;
                $display("FAIL bp_hold c=%0d: valid=%b data=%h, required 1 30000000", c, valid, data);
            end
            step();
        end
        ready = 1'b1;
        total++;
        if (valid !== 1'b1 || data !== 32'h30000000) begin
            bad++;
            $display("FAIL bp_first: valid=%b data=%h, required 1 30000000", valid, data);
        end
        step();
        total++;
        if (valid !== 1'b1 || data !== 32'h34070005) begin
            bad++;
            $display("FAIL bp_second: valid=%b data=%h, required 1 34070005", valid, data);
        end
        step();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle: valid=%b busy=%b, required 0 0", valid, busy);
        end
    endtask

    task automatic test_period();
        logic [31:0] last;
        int xs [3];
        xs = '{1, 2, 0};
        do_reset();
        cfg(0, 7, 3); cfg(0, 0, 1); cfg(0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            run_frame(100, last);
            total++;
            if (last[9:0] !== 10'(xs[i]) || fc !== PW'(xs[i])) begin
                bad++;
                $display("FAIL period i=%0d: x=%0d fc=%0d, required %0d %0d", i, last[9:0], fc, xs[i], xs[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        cfg(0, 0, 1); cfg(0, 1, 1);
        ready = 1'b0;
        tick();
        for (int c = 0; c < NL; c++) step();
        tick();
        for (int c = 0; c < 3; c++) step();
        total++;
        if (overrun !== 1'b1 || fc !== PW'(1) || valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun: ovr=%b fc=%0d valid=%b, required 1 1 1", overrun, fc, valid);
        end
        ready = 1'b1;
        step();
        n = 0;
        for (int c = 0; c < 2 * NL + 2; c++) begin
            if (valid === 1'b1) n++;
            step();
        end
        total++;
        if (n != 0 || busy !== 1'b0 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_after: extra=%0d busy=%b ovr=%b, required 0 0 1", n, busy, overrun);
        end
        // Reset in the middle of an EMIT with a stalled consumer
        ready = 1'b0;
        tick();
        for (int c = 0; c < NL; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || fc !== '0 || data !== '0) begin
            bad++;
            $display("FAIL midreset: valid=%b busy=%b ovr=%b fc=%0d data=%h, required all 0",
                     valid, busy, overrun, fc, data);
        end
        ready = 1'b1;
        n = 0;
        for (int c = 0; c < NL + 3; c++) begin
            if (valid === 1'b1 || busy === 1'b1) n++;
            step();
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL midreset_quiet: active cycles=%0d, required 0", n);
        end
    endtask

    task automatic test_none();
        logic [31:0] last;
        do_reset();
        cfg(1, 1, 3);
        run_frame(100, last);
    endtask

    task automatic test_random();
        logic [31:0] last;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int l = 0; l < NL; l++) begin
                int wx, wy;
                wx = $urandom_range(8, 1000);
                wy = $urandom_range(8, 500);
                cfg(l, 3, wx);
                cfg(l, 4, wy);
                cfg(l, 5, $urandom_range(0, wx));
                cfg(l, 6, $urandom_range(0, wy));
                cfg(l, 1, $urandom_range(0, 15));
                cfg(l, 2, $urandom_range(0, 15));
                cfg(l, 0, $urandom_range(0, 1));
            end
            cfg(5, 5, 123);
            cfg(6, 7, $urandom_range(0, 5));
            for (int f = 0; f < 8; f++) begin
                if ($urandom_range(0, 3) == 0) cfg($urandom_range(0, NL - 1), 0, $urandom_range(0, 1));
                run_frame($urandom_range(30, 100), last);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_period();
        test_overrun();
        test_none();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scroll_sequencer.md
# scroll_sequencer

Parametrised per-frame scroll command generator for the ogege graphics pipeline. It replaces the hard-wired single-layer scroll animation in the top level. It holds per-layer X/Y scroll offsets, signed velocities, wrap limits and enables, and steps them once per frame at the last visible pixel. It then emits one 32-bit scroll command per enabled layer to the text-area command port through a valid/ready handshake.

## Interface
Parameters:
- NUM_LAYERS, 4: layer count, 1..8. The layer index is carried in command bits [27:25].
- HSZ, 10 / VSZ, 9: widths of the scan column and scan row counters.
- HRES, 640 / VRES, 480: active resolution, used for frame-end detection.
- VW, 4: signed velocity width.
- PW, 6: frame-period and frame-count width.
- WRAP_X_DEF, 671 / WRAP_Y_DEF, 511: reset wrap limits.
- PERIOD_DEF, 60: reset frame period.

Ports (reset is synchronous and active-high; one clock):
- i_pix_clk  in  1  pixel clock, the only clock.
- i_rst  in  1  synchronous active-high reset.
- i_scan_column  in  HSZ  current column from vga_core.
- i_scan_row  in  VSZ  current row from vga_core.
- i_cfg_we  in  1  configuration write strobe.
- i_cfg_layer  in  3  target layer. Writes with a layer index of NUM_LAYERS or above are ignored, except for field 7.
- i_cfg_field  in  3  register select: 0 enable (bit 0), 1 vel_x, 2 vel_y, 3 wrap_x, 4 wrap_y, 5 offset_x, 6 offset_y, 7 period (global).
- i_cfg_data  in  16  write data, LSB-aligned. Velocities take the low VW bits, sign-extended.
- o_cmd_valid  out  1  command available.
- i_cmd_ready  in  1  command consumer accepts. The top level ties this to 1 when it drives text_area8x8.
- o_cmd_data  out  32  {4'b0011, layer[2:0], y[8:0], 6'b0, x[9:0]}.
- o_busy  out  1  sequencer is not in IDLE.
- o_overrun  out  1  sticky; set when a frame end arrives while busy; cleared only by reset.
- o_frame_count  out  PW  frames since the last period rollover.

## Operation
- Frame end (tick): the cycle in which i_scan_column == HRES-1 and i_scan_row == VRES-1.
- The FSM has three states: IDLE, UPDATE and EMIT.
- IDLE:
  - On a tick, go to UPDATE with layer index 0.
  - Update the frame counter at the same time:
    - If period != 0 and frame_count == period-1, the tick is a rollover: frame_count <= 0.
    - Otherwise frame_count <= frame_count+1, wrapping modulo 2^PW.
- UPDATE visits one layer per cycle, indices 0..NUM_LAYERS-1.
  - Enabled layer on a rollover tick: offsets are set to 0.
  - Enabled layer otherwise: each axis steps to offset+vel and wraps.
    - If the result is greater than wrap, subtract (wrap+1).
    - If the result is negative, add (wrap+1).
    - The step is computed at one bit wider than the offset width (X 10 bits, Y 9 bits).
    - Software guarantees |vel| <= wrap. Behaviour outside that range is undefined.
  - Disabled layer: offsets are unchanged.
  - After the last layer, go to EMIT with the index at the first enabled layer. If no layer is enabled, return to IDLE.
- EMIT:
  - Present the command for the current layer with o_cmd_valid=1.
  - On valid && ready, advance to the next enabled layer. After the last enabled layer, return to IDLE.
  - o_cmd_data stays stable while valid is high and ready is low.
- Config writes:
  - Writes apply in any state.
  - A write to the offset of the same layer in its UPDATE cycle wins over the step.
  - The enable value is sampled at UPDATE for the stepping decision and at EMIT for the skip decision.
- A tick while busy is dropped: o_overrun <= 1 and the frame counter is not advanced.

## Timing
- Reset values:
  - o_cmd_valid 0, o_busy 0, o_overrun 0, o_frame_count 0, o_cmd_data 0.
  - All offsets 0, velocities 0, enables 0.
  - Wrap limits WRAP_X_DEF and WRAP_Y_DEF; period PERIOD_DEF.
- Tick at cycle T:
  - o_busy=1 from T+1.
  - UPDATE occupies T+1..T+NUM_LAYERS.
  - The first o_cmd_valid appears at T+NUM_LAYERS+1.
- With ready held at 1, one command is emitted per cycle. o_busy falls the cycle after the last handshake.
- Reset is asserted mid-sequence: next cycle is IDLE with all outputs at reset values. No partial command is held.

## Structure
- Shared package ogege_pkg holds:
  - the opcode constant SCROLL_OP = 4'b0011;
  - the field encodings CFG_ENABLE..CFG_PERIOD;
  - the command bit-position constants;
  - the state enum (IDLE, UPDATE, EMIT).
- One sub-module, scroll_axis_step: a purely combinational, width-parametrised wrap adder taking offset, vel and wrap and producing the next offset. It is instantiated once for X and once for Y, shared across layers by the index mux.

## Test plan
- Layer 0 enabled, vel_x=+1, vel_y=+1, ready=1, one tick -> one command 0x30010001 at T+NUM_LAYERS+1; o_busy low after.
- Layer 0 offset_x=671, vel_x=+1, then a tick -> X=0. Offset_x=0, vel_x=-2 (wrap 671), then a tick -> X=670.
- Layers 0 and 2 enabled, layer 2 offsets x=5 y=7, vel 0, ready=0 for 3 cycles then 1 -> 0x30000000 held stable, then 0x34070005, then idle.
- Period=3, layer 0 vel_x=+1, three ticks -> X=1, 2, 0. o_frame_count reads 1, 2, 0.
- Ready=0 during EMIT, second tick arrives -> o_overrun=1 sticky, frame_count unchanged, no extra command. Then i_rst=1 for one cycle -> all outputs return to reset values.
- No layer enabled, tick -> busy for NUM_LAYERS cycles, no o_cmd_valid.
